csr_wr_arb: RTL and testbench
=============================

Name: csr_wr_arb

Overview:
- Arbiter for the single CSR-file write port, shared between two requesters:
  - the trap unit, which issues simultaneous mepc/mcause/mstatus write bundles on exceptions, interrupts and mret;
  - the EXU CSR-instruction path (csrrw/csrrs/csrrc and immediate forms).
- Serializes each trap bundle into back-to-back single writes, with fixed priority over the EXU.
- Holds the pipeline while a bundle drains.
- Sits between the trap unit and the CSR register file.

Parameters:
- ADDR_W, 12, CSR address width.
- DATA_W, 64, CSR data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- trap_mepc_wen_i  in  1  trap bundle: write mepc
- trap_mepc_wdata_i  in  DATA_W  mepc value
- trap_mcause_wen_i  in  1  trap bundle: write mcause
- trap_mcause_wdata_i  in  DATA_W  mcause value
- trap_mstatus_wen_i  in  1  trap bundle: write mstatus
- trap_mstatus_wdata_i  in  DATA_W  mstatus value
- exu_valid_i  in  1  EXU CSR write request
- exu_waddr_i  in  ADDR_W  EXU target CSR address
- exu_wdata_i  in  DATA_W  EXU write data
- exu_ready_o  out  1  EXU request accepted this cycle when valid&ready
- csr_wen_o  out  1  CSR file write enable (registered)
- csr_waddr_o  out  ADDR_W  CSR file write address (registered)
- csr_wdata_o  out  DATA_W  CSR file write data (registered)
- arb_hold_o  out  1  stall request to the pipeline
- trap_ovf_o  out  1  sticky: trap bundle dropped

Behaviour:
- trap_in = OR of the three trap wen inputs. A bundle is valid for exactly one cycle.
- pend[2:0] = {mstatus, mcause, mepc} outstanding flags, plus three DATA_W data latches.
- Service order within a bundle is fixed: mepc, then mcause, then mstatus. Disabled entries are skipped with no gap cycle.
- Per-edge priority (first matching rule wins):
  1. trap_in && pend==0:
     - drive the first enabled entry of the bundle onto csr_*_o;
     - load pend with the remaining enabled entries and latch their data.
  2. trap_in && pend!=0:
     - drop the new bundle and set trap_ovf_o = 1;
     - drain the current pend as in rule 3.
  3. pend!=0: drive the lowest set pend entry and clear that bit.
  4. exu_valid_i && exu_ready_o: drive csr_wen_o=1 with exu_waddr_i and exu_wdata_i.
  5. Otherwise csr_wen_o = 0. csr_waddr_o and csr_wdata_o hold their previous values.
- Addresses driven for trap writes: mstatus 0x300, mepc 0x341, mcause 0x342.
- Latency:
  - a trap bundle seen in cycle T produces its writes in cycles T+1, T+2, T+3 (fewer if fewer wens are set);
  - an EXU request accepted in cycle T produces its write in T+1.
- exu_ready_o = (pend==0) && !trap_in. This is combinational. The trap unit wins a same-cycle collision; the EXU must hold valid, address and data until accepted.
- arb_hold_o = trap_in || (pend!=0).
- A full bundle gives exactly 3 consecutive csr_wen_o cycles and blocks the EXU for cycles T..T+2. exu_ready_o rises in T+3.
- A bundle with only mstatus (mret) gives one write at T+1. exu_ready_o is high again in T+1.
- trap_ovf_o is cleared only by reset.
- Reset, including mid-drain, has these values:
  - pend = 0, csr_wen_o = 0, csr_waddr_o = 0, csr_wdata_o = 0, trap_ovf_o = 0;
  - the in-flight bundle is discarded.
- exu_ready_o is 0 while rst_n = 0.
- No read forwarding: readers observe the CSR file after its write edge.

Decomposition:
- Shared package csr_pkg holds:
  - the CSR address constants CSR_MSTATUS = 12'h300, CSR_MEPC = 12'h341, CSR_MCAUSE = 12'h342;
  - a pend-index enum (P_MEPC = 0, P_MCAUSE = 1, P_MSTATUS = 2).
- No sub-module. The lowest-set-bit selector is an inline function.

Test Plan:
- Full trap bundle (mepc=0x8000_0010, mcause=11, mstatus=0xA00) in cycle 5 -> cycle 6 write 0x341/0x8000_0010, cycle 7 0x342/11, cycle 8 0x300/0xA00; arb_hold_o high in cycles 5-7; exu_ready_o high in cycle 8.
- mret bundle with only mstatus=0x88 -> single write 0x300/0x88 next cycle; hold lasts 1 cycle.
- EXU valid (0x305, 0x8000_0000) in the same cycle as a full bundle -> EXU not accepted; the three trap writes come first, then 0x305 is written in cycle T+4.
- Second bundle arriving while pend!=0 -> trap_ovf_o=1 and stays high; only the first bundle's 3 writes appear.
- Back-to-back EXU writes with no traps -> one write per cycle, each 1 cycle after acceptance; exu_ready_o stays 1.
- Reset asserted in cycle T+1 of a full bundle -> csr_wen_o=0 from the next edge onward; no mcause/mstatus write appears; pend=0 after reset.

Source files
------------

// File: rtl/csr_wr_arb_pkg.sv
// Shared CSR definitions for the write-port arbiter: fixed trap CSR
// addresses, the index of each entry in the pending vector, and the
// mapping from a pending index to its CSR address.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Bit positions in the pending vector; the numeric order is also the
  // service order inside one trap bundle.
  typedef enum logic [1:0] {
    P_MEPC    = 2'd0,
    P_MCAUSE  = 2'd1,
    P_MSTATUS = 2'd2
  } pend_idx_e;

  function automatic logic [11:0] csr_addr_of(input pend_idx_e idx);
    case (idx)
      P_MEPC:   return CSR_MEPC;
      P_MCAUSE: return CSR_MCAUSE;
      default:  return CSR_MSTATUS;
    endcase
  endfunction

endpackage

// File: rtl/csr_wr_arb_if.sv
// Bundle of trap-unit, EXU and CSR-file write signals around the arbiter.
// master: the environment (trap unit, EXU, CSR file); slave: the arbiter.
interface csr_wr_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);

  logic              trap_mepc_wen_i;
  logic [DATA_W-1:0] trap_mepc_wdata_i;
  logic              trap_mcause_wen_i;
  logic [DATA_W-1:0] trap_mcause_wdata_i;
  logic              trap_mstatus_wen_i;
  logic [DATA_W-1:0] trap_mstatus_wdata_i;
  logic              exu_valid_i;
  logic [ADDR_W-1:0] exu_waddr_i;
  logic [DATA_W-1:0] exu_wdata_i;
  logic              exu_ready_o;
  logic              csr_wen_o;
  logic [ADDR_W-1:0] csr_waddr_o;
  logic [DATA_W-1:0] csr_wdata_o;
  logic              arb_hold_o;
  logic              trap_ovf_o;

  modport master (
    output trap_mepc_wen_i, trap_mepc_wdata_i,
    output trap_mcause_wen_i, trap_mcause_wdata_i,
    output trap_mstatus_wen_i, trap_mstatus_wdata_i,
    output exu_valid_i, exu_waddr_i, exu_wdata_i,
    input  exu_ready_o, csr_wen_o, csr_waddr_o, csr_wdata_o,
    input  arb_hold_o, trap_ovf_o
  );

  modport slave (
    input  trap_mepc_wen_i, trap_mepc_wdata_i,
    input  trap_mcause_wen_i, trap_mcause_wdata_i,
    input  trap_mstatus_wen_i, trap_mstatus_wdata_i,
    input  exu_valid_i, exu_waddr_i, exu_wdata_i,
    output exu_ready_o, csr_wen_o, csr_waddr_o, csr_wdata_o,
    output arb_hold_o, trap_ovf_o
  );

endinterface

// File: rtl/csr_wr_arb.sv
// CSR-file write-port arbiter. A trap bundle (mepc/mcause/mstatus, valid for
// one cycle) is serialized into back-to-back single writes and always wins
// over the EXU CSR-instruction path. While a bundle drains the pipeline is
// held; a second bundle arriving mid-drain is dropped and flagged sticky.
module csr_wr_arb
  import csr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input logic         clk,
  input logic         rst_n,
  csr_wr_arb_if.slave bus
);

  logic              trap_in;
  logic [2:0]        trap_vec;
  logic [DATA_W-1:0] trap_wdata [3];

  logic [2:0]        pend_reg, pend_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              ovf_reg, ovf_next;
  logic [DATA_W-1:0] lat_reg [3];
  logic              load_bundle;
  logic              exu_ready;
  pend_idx_e         sel;

  // Lowest set bit wins: this is what fixes mepc -> mcause -> mstatus order
  // and lets disabled entries be skipped without a bubble.
  function automatic pend_idx_e lowest_set(input logic [2:0] v);
    if (v[0])      return P_MEPC;
    else if (v[1]) return P_MCAUSE;
    else           return P_MSTATUS;
  endfunction

  assign trap_vec = {bus.trap_mstatus_wen_i, bus.trap_mcause_wen_i, bus.trap_mepc_wen_i};
  assign trap_in  = |trap_vec;

  assign trap_wdata[P_MEPC]    = bus.trap_mepc_wdata_i;
  assign trap_wdata[P_MCAUSE]  = bus.trap_mcause_wdata_i;
  assign trap_wdata[P_MSTATUS] = bus.trap_mstatus_wdata_i;

  // EXU is only accepted on a completely idle cycle; rst_n gating keeps it
  // low while the block is held in reset.
  assign exu_ready = rst_n && (pend_reg == 3'b000) && !trap_in;

  // Write-port selection: new bundle, then draining bundle, then EXU.
  always_comb begin
    pend_next   = pend_reg;
    wen_next    = 1'b0;
    waddr_next  = waddr_reg;
    wdata_next  = wdata_reg;
    ovf_next    = ovf_reg;
    load_bundle = 1'b0;
    sel         = P_MEPC;
    if (trap_in && (pend_reg == 3'b000)) begin
      sel         = lowest_set(trap_vec);
      wen_next    = 1'b1;
      waddr_next  = ADDR_W'(csr_addr_of(sel));
      wdata_next  = trap_wdata[sel];
      pend_next   = trap_vec & ~(3'b001 << sel);
      load_bundle = 1'b1;
    end else if (pend_reg != 3'b000) begin
      // A bundle overlapping a drain is lost; only the flag records it.
      if (trap_in) ovf_next = 1'b1;
      sel        = lowest_set(pend_reg);
      wen_next   = 1'b1;
      waddr_next = ADDR_W'(csr_addr_of(sel));
      wdata_next = lat_reg[sel];
      pend_next  = pend_reg & ~(3'b001 << sel);
    end else if (bus.exu_valid_i && exu_ready) begin
      wen_next   = 1'b1;
      waddr_next = bus.exu_waddr_i;
      wdata_next = bus.exu_wdata_i;
    end
  end

  // Control and output registers; reset discards any in-flight bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_reg  <= 3'b000;
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      pend_reg  <= pend_next;
      wen_reg   <= wen_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Bundle data latches: only read while the matching pend bit is set, so
  // they need no reset and load only entries the bundle actually enables.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    // Capture one bundle entry when a fresh bundle is accepted.
    always_ff @(posedge clk) begin
      if (load_bundle && trap_vec[gi]) lat_reg[gi] <= trap_wdata[gi];
    end
  end

  assign bus.exu_ready_o = exu_ready;
  assign bus.csr_wen_o   = wen_reg;
  assign bus.csr_waddr_o = waddr_reg;
  assign bus.csr_wdata_o = wdata_reg;
  assign bus.arb_hold_o  = trap_in || (pend_reg != 3'b000);
  assign bus.trap_ovf_o  = ovf_reg;

endmodule

// File: tb/tb_csr_wr_arb.sv
// Scoreboard bench for csr_wr_arb: expected CSR writes (address, data and
// the cycle they must appear in) are queued when stimulus is driven and
// checked by a monitor whenever csr_wen_o is high.
module tb_csr_wr_arb;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  csr_wr_arb_if #(.ADDR_W(12), .DATA_W(64)) bus ();

  csr_wr_arb #(.ADDR_W(12), .DATA_W(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_trap(input logic me, input logic [63:0] mv, input logic ce,
                          input logic [63:0] cv, input logic se, input logic [63:0] sv);
    bus.trap_mepc_wen_i      = me;
    bus.trap_mepc_wdata_i    = mv;
    bus.trap_mcause_wen_i    = ce;
    bus.trap_mcause_wdata_i  = cv;
    bus.trap_mstatus_wen_i   = se;
    bus.trap_mstatus_wdata_i = sv;
  endtask

  task automatic push_exp(input logic [11:0] a, input logic [63:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // Monitor: every write on the CSR port must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.csr_wen_o !== 1'b0) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_write", 64'(bus.csr_wen_o), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("wr_addr", 64'(bus.csr_waddr_o), 64'(e.addr));
        check_eq("wr_data", bus.csr_wdata_o, e.data);
        check_eq("wr_cycle", 64'(cyc), 64'(e.cyc));
        $display("write cyc=%0d addr=0x%0h data=0x%0h", cyc, bus.csr_waddr_o, bus.csr_wdata_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int acc_cyc;
    logic accepted;
    logic [63:0] d;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_trap(0, 0, 0, 0, 0, 0);
    bus.exu_valid_i = 1'b0;
    bus.exu_waddr_i = '0;
    bus.exu_wdata_i = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_wen", 64'(bus.csr_wen_o), 64'd0);
    check_eq("rst_waddr", 64'(bus.csr_waddr_o), 64'd0);
    check_eq("rst_wdata", bus.csr_wdata_o, 64'd0);
    check_eq("rst_ovf", 64'(bus.trap_ovf_o), 64'd0);
    check_eq("rst_ready", 64'(bus.exu_ready_o), 64'd0);
    check_eq("rst_hold", 64'(bus.arb_hold_o), 64'd0);
    tick();
    rst_n = 1'b1;
    while (cyc < 5) tick();

    // Full bundle in cycle T=5
    t = cyc;
    set_trap(1, 64'h8000_0010, 1, 64'd11, 1, 64'hA00);
    push_exp(12'h341, 64'h8000_0010, t + 1);
    push_exp(12'h342, 64'd11, t + 2);
    push_exp(12'h300, 64'hA00, t + 3);
    $display("trap full bundle cyc=%0d", t);
    @(negedge clk);
    check_eq("full_hold_T", 64'(bus.arb_hold_o), 64'd1);
    check_eq("full_ready_T", 64'(bus.exu_ready_o), 64'd0);
    tick();
    set_trap(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("full_hold_T1", 64'(bus.arb_hold_o), 64'd1);
    check_eq("full_ready_T1", 64'(bus.exu_ready_o), 64'd0);
    tick();
    @(negedge clk);
    check_eq("full_hold_T2", 64'(bus.arb_hold_o), 64'd1);
    check_eq("full_ready_T2", 64'(bus.exu_ready_o), 64'd0);
    tick();
    @(negedge clk);
    check_eq("full_hold_T3", 64'(bus.arb_hold_o), 64'd0);
    check_eq("full_ready_T3", 64'(bus.exu_ready_o), 64'd1);
    repeat (2) tick();

    // mret: mstatus only
    t = cyc;
    set_trap(0, 64'h1234, 0, 64'h5678, 1, 64'h88);
    push_exp(12'h300, 64'h88, t + 1);
    $display("trap mret bundle cyc=%0d", t);
    @(negedge clk);
    check_eq("mret_hold_T", 64'(bus.arb_hold_o), 64'd1);
    tick();
    set_trap(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("mret_hold_T1", 64'(bus.arb_hold_o), 64'd0);
    check_eq("mret_ready_T1", 64'(bus.exu_ready_o), 64'd1);
    repeat (2) tick();

    // EXU collides with a full bundle
    t = cyc;
    set_trap(1, 64'h4000_0100, 1, 64'd2, 1, 64'h1880);
    bus.exu_valid_i = 1'b1;
    bus.exu_waddr_i = 12'h305;
    bus.exu_wdata_i = 64'h8000_0000;
    push_exp(12'h341, 64'h4000_0100, t + 1);
    push_exp(12'h342, 64'd2, t + 2);
    push_exp(12'h300, 64'h1880, t + 3);
    push_exp(12'h305, 64'h8000_0000, t + 4);
    $display("trap+exu collision cyc=%0d", t);
    @(negedge clk);
    check_eq("coll_ready_T", 64'(bus.exu_ready_o), 64'd0);
    tick();
    set_trap(0, 0, 0, 0, 0, 0);
    accepted = 1'b0;
    acc_cyc  = 0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      @(negedge clk);
      if (bus.exu_ready_o === 1'b1) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
      end
      tick();
    end
    bus.exu_valid_i = 1'b0;
    check_eq("coll_accepted", 64'(accepted), 64'd1);
    check_eq("coll_accept_cycle", 64'(acc_cyc), 64'(t + 3));
    repeat (2) tick();

    // Back-to-back EXU writes
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      bus.exu_valid_i = 1'b1;
      bus.exu_waddr_i = 12'h340 + 12'(i);
      bus.exu_wdata_i = d;
      push_exp(12'h340 + 12'(i), d, cyc + 1);
      $display("exu req cyc=%0d addr=0x%0h", cyc, 12'h340 + 12'(i));
      @(negedge clk);
      check_eq("b2b_ready", 64'(bus.exu_ready_o), 64'd1);
      tick();
    end
    bus.exu_valid_i = 1'b0;
    repeat (2) tick();

    // Second bundle during drain is dropped
    t = cyc;
    set_trap(1, 64'hAAAA_0000, 1, 64'd7, 1, 64'h80);
    push_exp(12'h341, 64'hAAAA_0000, t + 1);
    push_exp(12'h342, 64'd7, t + 2);
    push_exp(12'h300, 64'h80, t + 3);
    $display("trap bundle A cyc=%0d", t);
    @(negedge clk);
    check_eq("ovf_T", 64'(bus.trap_ovf_o), 64'd0);
    tick();
    set_trap(1, 64'hBBBB_0000, 1, 64'd9, 1, 64'h99);
    $display("trap bundle B (overlap) cyc=%0d", cyc);
    @(negedge clk);
    check_eq("ovf_T1", 64'(bus.trap_ovf_o), 64'd0);
    check_eq("ovf_ready_T1", 64'(bus.exu_ready_o), 64'd0);
    tick();
    set_trap(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("ovf_T2", 64'(bus.trap_ovf_o), 64'd1);
    repeat (4) tick();
    @(negedge clk);
    check_eq("ovf_sticky", 64'(bus.trap_ovf_o), 64'd1);
    tick();

    // Reset during a drain
    t = cyc;
    set_trap(1, 64'hCCCC_0004, 1, 64'd3, 1, 64'h8);
    push_exp(12'h341, 64'hCCCC_0004, t + 1);
    $display("trap bundle then reset cyc=%0d", t);
    tick();
    set_trap(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready", 64'(bus.exu_ready_o), 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_wen", 64'(bus.csr_wen_o), 64'd0);
    check_eq("post_rst_waddr", 64'(bus.csr_waddr_o), 64'd0);
    check_eq("post_rst_wdata", bus.csr_wdata_o, 64'd0);
    check_eq("post_rst_ovf", 64'(bus.trap_ovf_o), 64'd0);
    check_eq("post_rst_hold", 64'(bus.arb_hold_o), 64'd0);
    tick();
    @(negedge clk);
    check_eq("post_rst_hold2", 64'(bus.arb_hold_o), 64'd0);
    check_eq("post_rst_ready", 64'(bus.exu_ready_o), 64'd1);
    repeat (4) tick();

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
